// File: rtl/sound_arbiter_pkg.sv
// Shared types, tone tables and duration helpers for the buzzer arbiter.
// The high-score ROM rows exist only when SND_HS_JINGLE_EN is defined.
package sound_arbiter_pkg;

  localparam int SND_DIV_W = 16;
  localparam int SND_CNT_W = 24;

  typedef enum logic [1:0] {
    SND_IDLE_S  = 2'd0,
    SND_COLOR_S = 2'd1,
    SND_NOTE_S  = 2'd2,
    SND_GAP_S   = 2'd3
  } snd_state_e;

  typedef enum logic [2:0] {
    SND_SRC_NONE  = 3'd0,
    SND_SRC_COLOR = 3'd1,
    SND_SRC_START = 3'd2,
    SND_SRC_WIN   = 3'd3,
    SND_SRC_LOSE  = 3'd4,
    SND_SRC_HS    = 3'd5
  } snd_src_e;

  localparam logic [SND_DIV_W-1:0] COLOR_DIV [4] = '{16'd9556, 16'd7584, 16'd6378, 16'd4778};

  // A zero entry is a rest: the note slot stays silent.
  localparam logic [SND_DIV_W-1:0] START_ROM [4] = '{16'd9556, 16'd7584, 16'd6378, 16'd4778};
  localparam logic [SND_DIV_W-1:0] WIN_ROM   [4] = '{16'd6378, 16'd4778, 16'd0,    16'd4778};
  localparam logic [SND_DIV_W-1:0] LOSE_ROM  [4] = '{16'd4778, 16'd6378, 16'd7584, 16'd9556};
`ifdef SND_HS_JINGLE_EN
  localparam logic [SND_DIV_W-1:0] HS_ROM    [4] = '{16'd4778, 16'd0,    16'd4778, 16'd3189};
`endif

  function automatic logic [SND_DIV_W-1:0] jingle_div(input snd_src_e src, input logic [1:0] idx);
    logic [SND_DIV_W-1:0] div;
    div = '0;
    case (src)
      SND_SRC_START: div = START_ROM[idx];
      SND_SRC_WIN:   div = WIN_ROM[idx];
      SND_SRC_LOSE:  div = LOSE_ROM[idx];
`ifdef SND_HS_JINGLE_EN
      SND_SRC_HS:    div = HS_ROM[idx];
`endif
      default:       div = '0;
    endcase
    return div;
  endfunction

  // Zero-length durations behave as one cycle.
  function automatic logic [SND_CNT_W-1:0] eff_len(input logic [SND_CNT_W-1:0] len);
    return (len == '0) ? SND_CNT_W'(1) : len;
  endfunction

  function automatic logic [SND_CNT_W-1:0] max_len(input logic [SND_CNT_W-1:0] a,
                                                   input logic [SND_CNT_W-1:0] b);
    return (eff_len(a) > eff_len(b)) ? eff_len(a) : eff_len(b);
  endfunction

endpackage

// File: rtl/sound_arbiter_timer.sv
// Saturating duration counter: cleared on clr_i, runs when started, holds at MAX_COUNT-1.
// Count is registered (visible the cycle after clr_i); no backpressure.
module sound_arbiter_timer
  import sound_arbiter_pkg::*;
#(
  parameter int                CNT_W     = SND_CNT_W,
  parameter logic [CNT_W-1:0]  MAX_COUNT = CNT_W'(1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             start_tmr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             pulse_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             run_q, run_d;
  logic             terminal;

  assign terminal = (count_q == MAX_COUNT - CNT_W'(1));

  always_comb begin
    count_d = count_q;
    run_d   = run_q;
    if (clr_i) begin
      count_d = '0;
      run_d   = start_tmr_i;
    end else if (run_q && !terminal) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
      run_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      run_q   <= run_d;
    end
  end

  assign count_o = count_q;
  assign pulse_o = run_q && terminal;

endmodule

// File: rtl/sound_arbiter.sv
// Shares one tone generator between the live colour tone and 4-note jingles; registered outputs, 1-cycle latency.
// Jingles are never preempted; later requests wait as pending. SND_HS_JINGLE_EN enables the high-score jingle.
module sound_arbiter
  import sound_arbiter_pkg::*;
#(
  parameter logic [SND_CNT_W-1:0] NOTE_LEN = 24'd2_000_000,
  parameter logic [SND_CNT_W-1:0] GAP_LEN  = 24'd400_000,
  parameter int                   DIV_W    = SND_DIV_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             color_req_i,
  input  logic [1:0]       color_i,
  input  logic             start_req_i,
  input  logic             win_req_i,
  input  logic             lose_req_i,
  input  logic             hs_req_i,
  output logic [DIV_W-1:0] tone_div_o,
  output logic             tone_ena_o,
  output logic [2:0]       src_o,
  output logic             busy_o
);

  localparam logic [SND_CNT_W-1:0] NOTE_M1 = eff_len(NOTE_LEN) - SND_CNT_W'(1);
  localparam logic [SND_CNT_W-1:0] GAP_M1  = eff_len(GAP_LEN) - SND_CNT_W'(1);
  localparam logic [SND_CNT_W-1:0] MAX_CNT = max_len(NOTE_LEN, GAP_LEN);

  snd_state_e state_q, state_d;
  snd_src_e   jsrc_q, jsrc_d;
  logic [1:0] idx_q, idx_d;

  logic pend_start_q, pend_start_d;
  logic pend_win_q, pend_win_d;
  logic pend_lose_q, pend_lose_d;
  logic pend_hs_q, pend_hs_d;
  logic set_start, set_win, set_lose;
  logic grant_start, grant_win, grant_lose, grant_hs;
  logic playing, new_req, any_pend;

  logic [SND_CNT_W-1:0] tmr_count, dur_m1;
  logic                 tmr_pulse, tmr_clr, tmr_start, dur_done;

  logic [DIV_W-1:0] tone_div_q, tone_div_d;
  logic             tone_ena_q, tone_ena_d;
  snd_src_e         src_q, src_d;
  logic             busy_q, busy_d;
  logic [DIV_W-1:0] note_div;

  // A request for the jingle currently sounding is dropped, not queued.
  assign playing   = (state_q == SND_NOTE_S) || (state_q == SND_GAP_S);
  assign set_start = start_req_i && !(playing && jsrc_q == SND_SRC_START);
  assign set_win   = win_req_i   && !(playing && jsrc_q == SND_SRC_WIN);
  assign set_lose  = lose_req_i  && !(playing && jsrc_q == SND_SRC_LOSE);

`ifdef SND_HS_JINGLE_EN
  logic set_hs;
  assign set_hs    = hs_req_i && !(playing && jsrc_q == SND_SRC_HS);
  assign pend_hs_d = (pend_hs_q | set_hs) & ~grant_hs;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pend_hs_q <= 1'b0;
    else          pend_hs_q <= pend_hs_d;
  end
  assign new_req = set_start | set_win | set_lose | set_hs;
`else
  logic unused_hs;
  assign unused_hs = hs_req_i ^ grant_hs;
  assign pend_hs_q = 1'b0;
  assign pend_hs_d = 1'b0;
  assign new_req   = set_start | set_win | set_lose;
`endif

  assign any_pend = pend_start_q | pend_win_q | pend_lose_q | pend_hs_q;

  assign dur_m1   = (state_q == SND_GAP_S) ? GAP_M1 : NOTE_M1;
  assign dur_done = tmr_pulse || (tmr_count == dur_m1);

  always_comb begin
    state_d     = state_q;
    jsrc_d      = jsrc_q;
    idx_d       = idx_q;
    grant_start = 1'b0;
    grant_win   = 1'b0;
    grant_lose  = 1'b0;
    grant_hs    = 1'b0;
    case (state_q)
      SND_IDLE_S: begin
        if (any_pend) begin
          state_d = SND_NOTE_S;
          idx_d   = 2'd0;
          if (pend_lose_q) begin
            grant_lose = 1'b1;
            jsrc_d     = SND_SRC_LOSE;
          end else if (pend_win_q) begin
            grant_win = 1'b1;
            jsrc_d    = SND_SRC_WIN;
          end else if (pend_hs_q) begin
            grant_hs = 1'b1;
            jsrc_d   = SND_SRC_HS;
          end else begin
            grant_start = 1'b1;
            jsrc_d      = SND_SRC_START;
          end
        end else if (color_req_i && !new_req) begin
          state_d = SND_COLOR_S;
        end
      end
      SND_COLOR_S: begin
        // Drop the colour tone the moment a jingle is wanted; IDLE grants it next.
        if (any_pend || new_req || !color_req_i) state_d = SND_IDLE_S;
      end
      SND_NOTE_S: begin
        if (dur_done) state_d = SND_GAP_S;
      end
      SND_GAP_S: begin
        if (dur_done) begin
          if (idx_q == 2'd3) begin
            state_d = SND_IDLE_S;
          end else begin
            state_d = SND_NOTE_S;
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      default: state_d = SND_IDLE_S;
    endcase
  end

  assign pend_start_d = (pend_start_q | set_start) & ~grant_start;
  assign pend_win_d   = (pend_win_q   | set_win)   & ~grant_win;
  assign pend_lose_d  = (pend_lose_q  | set_lose)  & ~grant_lose;

  assign tmr_clr   = (state_d != state_q);
  assign tmr_start = tmr_clr && ((state_d == SND_NOTE_S) || (state_d == SND_GAP_S));

  sound_arbiter_timer #(
    .CNT_W     (SND_CNT_W),
    .MAX_COUNT (MAX_CNT)
  ) note_timer_u1 (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clr_i       (tmr_clr),
    .start_tmr_i (tmr_start),
    .count_o     (tmr_count),
    .pulse_o     (tmr_pulse)
  );

  assign note_div = DIV_W'(jingle_div(jsrc_d, idx_d));

  // Outputs are decoded from next state so they change one cycle after the sampled inputs.
  always_comb begin
    tone_div_d = '0;
    tone_ena_d = 1'b0;
    src_d      = SND_SRC_NONE;
    case (state_d)
      SND_COLOR_S: begin
        tone_div_d = DIV_W'(COLOR_DIV[color_i]);
        tone_ena_d = 1'b1;
        src_d      = SND_SRC_COLOR;
      end
      SND_NOTE_S: begin
        tone_div_d = note_div;
        tone_ena_d = (note_div != '0);
        src_d      = jsrc_d;
      end
      SND_GAP_S: src_d = jsrc_d;
      default: ;
    endcase
    busy_d = (state_d == SND_NOTE_S) || (state_d == SND_GAP_S) ||
             pend_start_d || pend_win_d || pend_lose_d || pend_hs_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= SND_IDLE_S;
      jsrc_q       <= SND_SRC_NONE;
      idx_q        <= 2'd0;
      pend_start_q <= 1'b0;
      pend_win_q   <= 1'b0;
      pend_lose_q  <= 1'b0;
      tone_div_q   <= '0;
      tone_ena_q   <= 1'b0;
      src_q        <= SND_SRC_NONE;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      jsrc_q       <= jsrc_d;
      idx_q        <= idx_d;
      pend_start_q <= pend_start_d;
      pend_win_q   <= pend_win_d;
      pend_lose_q  <= pend_lose_d;
      tone_div_q   <= tone_div_d;
      tone_ena_q   <= tone_ena_d;
      src_q        <= src_d;
      busy_q       <= busy_d;
    end
  end

  assign tone_div_o = tone_div_q;
  assign tone_ena_o = tone_ena_q;
  assign src_o      = src_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Scoreboarded bench for sound_arbiter with NOTE_LEN=8, GAP_LEN=2: stimulus pushes expected outputs, a monitor compares.
module tb_sound_arbiter;

  localparam int NL   = 8;
  localparam int GL   = 2;
  localparam int SLOT = NL + GL;
  localparam int JLEN = 4 * SLOT;

  typedef struct {
    int div;
    bit ena;
    int src;
    bit busy;
    int cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        color_req_i;
  logic [1:0]  color_i;
  logic        start_req_i, win_req_i, lose_req_i, hs_req_i;
  logic [15:0] tone_div;
  logic        tone_ena;
  logic [2:0]  src;
  logic        busy;

  sound_arbiter #(
    .NOTE_LEN (24'd8),
    .GAP_LEN  (24'd2),
    .DIV_W    (16)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .color_req_i (color_req_i),
    .color_i     (color_i),
    .start_req_i (start_req_i),
    .win_req_i   (win_req_i),
    .lose_req_i  (lose_req_i),
    .hs_req_i    (hs_req_i),
    .tone_div_o  (tone_div),
    .tone_ena_o  (tone_ena),
    .src_o       (src),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state: a jingle is described only by its grant cycle and source.
  int t = 0;
  int t0 = -1000;
  int jsrc = 0;
  bit color_mode = 0;
  bit pend[4];   // index 0 start, 1 high-score, 2 win, 3 lose (higher index wins)

  int cdiv[4] = '{9556, 7584, 6378, 4778};

  function automatic int code_of(input int i);
    case (i)
      0: return 2;
      1: return 5;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int rom_div(input int s, input int slot);
    int r_start[4] = '{9556, 7584, 6378, 4778};
    int r_win[4]   = '{6378, 4778, 0, 4778};
    int r_lose[4]  = '{4778, 6378, 7584, 9556};
    int r_hs[4]    = '{4778, 0, 4778, 3189};
    case (s)
      2: return r_start[slot];
      3: return r_win[slot];
      4: return r_lose[slot];
      default: return r_hs[slot];
    endcase
  endfunction

  task automatic model_reset();
    t0 = -1000;
    jsrc = 0;
    color_mode = 0;
    for (int i = 0; i < 4; i++) pend[i] = 0;
  endtask

  task automatic step(input bit creq, input logic [1:0] col, input bit st,
                      input bit wn, input bit ls, input bit hs);
    bit   req[4];
    bit   playing, any_old, any_new, jing, any_p;
    int   g, rel, slot, ph;
    exp_t e;
    color_req_i = creq;
    color_i     = col;
    start_req_i = st;
    win_req_i   = wn;
    lose_req_i  = ls;
    hs_req_i    = hs;
    req[0] = st;
    req[2] = wn;
    req[3] = ls;
`ifdef SND_HS_JINGLE_EN
    req[1] = hs;
`else
    req[1] = 1'b0;
`endif
    playing = (t >= t0 + 1) && (t <= t0 + JLEN);
    any_old = 0;
    any_new = 0;
    g = -1;
    for (int i = 0; i < 4; i++) begin
      any_old |= pend[i];
      if (req[i] && !(playing && jsrc == code_of(i))) any_new = 1;
    end
    jing = 0;
    if (playing) begin
      jing = (t != t0 + JLEN);
      color_mode = 0;
    end else if (!color_mode) begin
      if (any_old) begin
        for (int i = 0; i < 4; i++) if (pend[i]) g = i;
        pend[g] = 0;
        t0 = t;
        jsrc = code_of(g);
        jing = 1;
      end else begin
        color_mode = creq && !any_new;
      end
    end else begin
      color_mode = creq && !any_old && !any_new;
    end
    for (int i = 0; i < 4; i++)
      if (req[i] && !(playing && jsrc == code_of(i)) && g != i) pend[i] = 1;

    e.div = 0; e.ena = 0; e.src = 0;
    if (jing) begin
      rel  = t - t0;
      slot = rel / SLOT;
      ph   = rel % SLOT;
      e.src = jsrc;
      if (ph < NL) e.div = rom_div(jsrc, slot);
      e.ena = (e.div != 0);
    end else if (color_mode) begin
      e.div = cdiv[col];
      e.ena = 1;
      e.src = 1;
    end
    any_p = 0;
    for (int i = 0; i < 4; i++) any_p |= pend[i];
    e.busy = jing || any_p;
    e.cyc  = t;
    @(posedge clk);
    exp_q.push_back(e);
    t++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({tone_div, tone_ena, src, busy} !== {16'(mon_e.div), mon_e.ena, 3'(mon_e.src), mon_e.busy}) begin
        errors++;
        $display("FAIL cyc%0d: got div=%0d ena=%0d src=%0d busy=%0d, expected div=%0d ena=%0d src=%0d busy=%0d",
                 mon_e.cyc, tone_div, tone_ena, src, busy, mon_e.div, mon_e.ena, mon_e.src, mon_e.busy);
      end
    end
  end

  bit          r_creq;
  logic [1:0]  r_col;

  initial begin
    rst_n = 1'b0;
    color_req_i = 0; color_i = 0;
    start_req_i = 0; win_req_i = 0; lose_req_i = 0; hs_req_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_div", int'(tone_div), 0);
    chk("reset_ena", int'(tone_ena), 0);
    chk("reset_src", int'(src), 0);
    chk("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Colour tone held for 5 cycles, then a held tone with a colour change.
    repeat (5) step(1, 2'd2, 0, 0, 0, 0);
    idle(3);
    repeat (3) step(1, 2'd0, 0, 0, 0, 0);
    repeat (3) step(1, 2'd3, 0, 0, 0, 0);
    idle(2);

    // Start jingle, with a duplicate start request mid-jingle that must be ignored.
    step(0, 2'd0, 1, 0, 0, 0);
    idle(15);
    step(0, 2'd0, 1, 0, 0, 0);
    idle(30);

    // Win and lose together: lose first, then win; a start queued during lose waits.
    step(0, 2'd0, 0, 1, 1, 0);
    idle(10);
    step(0, 2'd0, 1, 0, 1, 0);
    idle(120);

    // Colour held, lose preempts it, colour stays ignored until lose finishes.
    repeat (5) step(1, 2'd1, 0, 0, 0, 0);
    step(1, 2'd1, 0, 0, 1, 0);
    repeat (48) step(1, 2'd1, 0, 0, 0, 0);
    idle(3);

    // Reset during note 2 of a start jingle.
    step(0, 2'd0, 1, 0, 0, 0);
    idle(24);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_div", int'(tone_div), 0);
    chk("midrst_ena", int'(tone_ena), 0);
    chk("midrst_src", int'(src), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(5);

    // High-score request: plays when the feature is built, otherwise leaves BUSY low.
    step(0, 2'd0, 0, 0, 0, 1);
    idle(45);
    step(0, 2'd0, 1, 0, 0, 1);
    idle(90);

    // Randomised traffic.
    r_creq = 0;
    r_col  = 2'd0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) r_creq = ~r_creq;
      if ($urandom_range(0, 7) == 0) r_col = 2'($urandom_range(0, 3));
      step(r_creq, r_col,
           $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 79) == 0, $urandom_range(0, 59) == 0);
    end
    idle(2);

    @(negedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
